// File: rtl/srm_controller.sv
// Control FSM for the Simple RISC Machine: fetches, decodes and sequences each
// instruction through the datapath, and owns the single memory port.
module srm_controller #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       load_ir,
    output logic       reset_pc,
    output logic       load_pc,
    output logic       load_addr,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] vsel,
    output logic [2:0] nsel,
    output logic       write,
    output logic       retire,
    output logic       halted,
    output logic       illegal,
    output logic       bus_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_UPC, S_DEC, S_WIMM, S_GETA, S_GETB, S_EXEC, S_CMP,
        S_WBC, S_ADDR, S_LDA, S_MRD, S_GETD, S_PASS, S_MWR, S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic            illegal_q, illegal_d;
    logic            bus_err_q, bus_err_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            in_mem_state;
    logic            timeout_hit;

    // Next-state logic; IR fields stay stable for the whole instruction, so
    // later states re-read opcode/op instead of keeping a decoded copy.
    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        bus_err_d    = bus_err_q;
        wait_cnt_d   = '0;
        in_mem_state = (state_q == S_IF1) || (state_q == S_MRD) || (state_q == S_MWR);
        if (in_mem_state && !mem_ready) begin
            wait_cnt_d = wait_cnt_q + CW'(1'b1);
        end
        timeout_hit = (TIMEOUT != 0) && in_mem_state && !mem_ready && (wait_cnt_q == LAST);

        case (state_q)
            S_RST:  state_d = S_IF1;
            S_IF1:  if (mem_ready) state_d = S_UPC;
            S_UPC:  state_d = S_DEC;
            S_DEC: begin
                casez ({opcode, op})
                    5'b110_10: state_d = S_WIMM;
                    5'b110_00: state_d = S_GETB;
                    5'b101_??: state_d = S_GETA;
                    5'b011_00: state_d = S_GETA;
                    5'b100_00: state_d = S_GETA;
                    5'b111_00: state_d = S_HALT;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_WIMM: state_d = S_IF1;
            S_GETA: state_d = (opcode == 3'b101) ? S_GETB : S_ADDR;
            S_GETB: state_d = ({opcode, op} == 5'b101_01) ? S_CMP : S_EXEC;
            S_EXEC: state_d = S_WBC;
            S_CMP:  state_d = S_IF1;
            S_WBC:  state_d = S_IF1;
            S_ADDR: state_d = S_LDA;
            S_LDA:  state_d = (opcode == 3'b011) ? S_MRD : S_GETD;
            S_MRD:  if (mem_ready) state_d = S_IF1;
            S_GETD: state_d = S_PASS;
            S_PASS: state_d = S_MWR;
            S_MWR:  if (mem_ready) state_d = S_IF1;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase

        if (timeout_hit) begin
            state_d    = S_HALT;
            bus_err_d  = 1'b1;
            wait_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RST;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Moore decode of the datapath controls; only the memory states look at mem_ready.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        load_ir   = 1'b0;
        reset_pc  = 1'b0;
        load_pc   = 1'b0;
        load_addr = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        vsel      = 2'b00;
        nsel      = 3'b000;
        write     = 1'b0;
        retire    = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_RST: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
            end
            S_IF1: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                load_ir  = mem_ready;
            end
            S_UPC:  load_pc = 1'b1;
            S_WIMM: begin
                vsel   = 2'b10;
                nsel   = 3'b100;
                write  = 1'b1;
                retire = 1'b1;
            end
            S_GETA: begin
                nsel  = 3'b100;
                loada = 1'b1;
            end
            S_GETB: begin
                nsel  = 3'b001;
                loadb = 1'b1;
            end
            S_EXEC: begin
                loadc = 1'b1;
                asel  = (opcode == 3'b110);
            end
            S_CMP: begin
                loads  = 1'b1;
                retire = 1'b1;
            end
            S_WBC: begin
                vsel   = 2'b00;
                nsel   = 3'b010;
                write  = 1'b1;
                retire = 1'b1;
            end
            S_ADDR: begin
                bsel  = 1'b1;
                loadc = 1'b1;
            end
            S_LDA:  load_addr = 1'b1;
            S_MRD: begin
                mem_req = 1'b1;
                vsel    = 2'b11;
                nsel    = 3'b010;
                write   = mem_ready;
                retire  = mem_ready;
            end
            S_GETD: begin
                nsel  = 3'b010;
                loadb = 1'b1;
            end
            S_PASS: begin
                asel  = 1'b1;
                loadc = 1'b1;
            end
            S_MWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                retire  = mem_ready;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_srm_controller.sv
// Directed testbench for srm_controller: walks each instruction class cycle by
// cycle and compares every control output against hand-derived vectors.
module tb_srm_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       mem_ready;
    logic       mem_req, mem_we, addr_sel, load_ir, reset_pc, load_pc, load_addr;
    logic       loada, loadb, loadc, loads, asel, bsel, write, retire;
    logic       halted, illegal, bus_err;
    logic [1:0] vsel;
    logic [2:0] nsel;

    int total  = 0;
    int passed = 0;

    srm_controller #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .load_ir(load_ir),
        .reset_pc(reset_pc), .load_pc(load_pc), .load_addr(load_addr),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .nsel(nsel), .write(write),
        .retire(retire), .halted(halted), .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    logic [23:0] ov;
    assign ov = {mem_req, mem_we, addr_sel, load_ir, reset_pc, load_pc, load_addr,
                 loada, loadb, loadc, loads, asel, bsel, vsel, nsel,
                 write, retire, halted, illegal, bus_err, 1'b0};

    localparam logic [23:0] O_MREQ  = 24'h800000;
    localparam logic [23:0] O_MWE   = 24'h400000;
    localparam logic [23:0] O_ADS   = 24'h200000;
    localparam logic [23:0] O_LIR   = 24'h100000;
    localparam logic [23:0] O_RPC   = 24'h080000;
    localparam logic [23:0] O_LPC   = 24'h040000;
    localparam logic [23:0] O_LADDR = 24'h020000;
    localparam logic [23:0] O_LA    = 24'h010000;
    localparam logic [23:0] O_LB    = 24'h008000;
    localparam logic [23:0] O_LC    = 24'h004000;
    localparam logic [23:0] O_LS    = 24'h002000;
    localparam logic [23:0] O_ASEL  = 24'h001000;
    localparam logic [23:0] O_BSEL  = 24'h000800;
    localparam logic [23:0] V_IMM   = 24'h000400;
    localparam logic [23:0] V_MEM   = 24'h000600;
    localparam logic [23:0] N_RN    = 24'h000100;
    localparam logic [23:0] N_RD    = 24'h000080;
    localparam logic [23:0] N_RM    = 24'h000040;
    localparam logic [23:0] O_WR    = 24'h000020;
    localparam logic [23:0] O_RET   = 24'h000010;
    localparam logic [23:0] O_HALT  = 24'h000008;
    localparam logic [23:0] O_ILL   = 24'h000004;
    localparam logic [23:0] O_BERR  = 24'h000002;

    localparam logic [23:0] E_RST  = O_RPC | O_LPC;
    localparam logic [23:0] E_IF1  = O_MREQ | O_ADS | O_LIR;
    localparam logic [23:0] E_IF1W = O_MREQ | O_ADS;
    localparam logic [23:0] E_UPC  = O_LPC;
    localparam logic [23:0] E_DEC  = 24'h000000;
    localparam logic [23:0] E_WIMM = V_IMM | N_RN | O_WR | O_RET;
    localparam logic [23:0] E_GETA = N_RN | O_LA;
    localparam logic [23:0] E_GETB = N_RM | O_LB;
    localparam logic [23:0] E_EXEC = O_LC;
    localparam logic [23:0] E_EXSH = O_LC | O_ASEL;
    localparam logic [23:0] E_WBC  = N_RD | O_WR | O_RET;
    localparam logic [23:0] E_CMP  = O_LS | O_RET;
    localparam logic [23:0] E_ADDR = O_BSEL | O_LC;
    localparam logic [23:0] E_LDA  = O_LADDR;
    localparam logic [23:0] E_MRD  = O_MREQ | V_MEM | N_RD | O_WR | O_RET;
    localparam logic [23:0] E_MRDW = O_MREQ | V_MEM | N_RD;
    localparam logic [23:0] E_GETD = N_RD | O_LB;
    localparam logic [23:0] E_PASS = O_ASEL | O_LC;
    localparam logic [23:0] E_MWR  = O_MREQ | O_MWE | O_RET;
    localparam logic [23:0] E_MWRW = O_MREQ | O_MWE;

    // One clock: mem_ready for the new state is applied after the edge, then outputs settle.
    task automatic tick(input logic rdy);
        @(posedge clk);
        #1;
        mem_ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b1);
        tick(1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1; opcode = 3'b110; op = 2'b10;
        for (int c = 0; c < 2; c++) begin
            tick(1'b1);
            total++;
            if (ov !== E_RST) $display("[TB] FAIL reset cycle %0d: got %h expected %h", c, ov, E_RST);
            else passed++;
        end
    endtask

    task automatic test_mov_imm();
        logic [23:0] ev[$];
        ev = '{E_IF1, E_UPC, E_DEC, E_WIMM, E_IF1};
        do_reset(); opcode = 3'b110; op = 2'b10; rst = 1'b0;
        for (int c = 0; c < ev.size(); c++) begin
            tick(1'b1);
            total++;
            if (ov !== ev[c]) $display("[TB] FAIL mov_imm cycle %0d: got %h expected %h", c + 1, ov, ev[c]);
            else passed++;
        end
    endtask

    task automatic test_mov_shift();
        logic [23:0] ev[$];
        ev = '{E_IF1, E_UPC, E_DEC, E_GETB, E_EXSH, E_WBC, E_IF1};
        do_reset(); opcode = 3'b110; op = 2'b00; rst = 1'b0;
        for (int c = 0; c < ev.size(); c++) begin
            tick(1'b1);
            total++;
            if (ov !== ev[c]) $display("[TB] FAIL mov_shift cycle %0d: got %h expected %h", c + 1, ov, ev[c]);
            else passed++;
        end
    endtask

    task automatic test_add();
        logic [23:0] ev[$];
        ev = '{E_IF1, E_UPC, E_DEC, E_GETA, E_GETB, E_EXEC, E_WBC, E_IF1};
        do_reset(); opcode = 3'b101; op = 2'b00; rst = 1'b0;
        for (int c = 0; c < ev.size(); c++) begin
            tick(1'b1);
            total++;
            if (ov !== ev[c]) $display("[TB] FAIL add cycle %0d: got %h expected %h", c + 1, ov, ev[c]);
            else passed++;
        end
    endtask

    task automatic test_cmp();
        logic [23:0] ev[$];
        ev = '{E_IF1, E_UPC, E_DEC, E_GETA, E_GETB, E_CMP, E_IF1};
        do_reset(); opcode = 3'b101; op = 2'b01; rst = 1'b0;
        for (int c = 0; c < ev.size(); c++) begin
            tick(1'b1);
            total++;
            if (ov !== ev[c]) $display("[TB] FAIL cmp cycle %0d: got %h expected %h", c + 1, ov, ev[c]);
            else passed++;
        end
    endtask

    task automatic test_ldr_wait();
        logic [23:0] ev[$];
        logic        rd[$];
        ev = '{E_IF1, E_UPC, E_DEC, E_GETA, E_ADDR, E_LDA, E_MRDW, E_MRDW, E_MRD, E_IF1};
        rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset(); opcode = 3'b011; op = 2'b00; rst = 1'b0;
        for (int c = 0; c < ev.size(); c++) begin
            tick(rd[c]);
            total++;
            if (ov !== ev[c]) $display("[TB] FAIL ldr_wait cycle %0d: got %h expected %h", c + 1, ov, ev[c]);
            else passed++;
        end
    endtask

    task automatic test_str();
        logic [23:0] ev[$];
        ev = '{E_IF1, E_UPC, E_DEC, E_GETA, E_ADDR, E_LDA, E_GETD, E_PASS, E_MWR, E_IF1};
        do_reset(); opcode = 3'b100; op = 2'b00; rst = 1'b0;
        for (int c = 0; c < ev.size(); c++) begin
            tick(1'b1);
            total++;
            if (ov !== ev[c]) $display("[TB] FAIL str cycle %0d: got %h expected %h", c + 1, ov, ev[c]);
            else passed++;
        end
    endtask

    task automatic test_halt();
        logic [23:0] ev[$];
        ev = '{E_IF1, E_UPC, E_DEC, O_HALT, O_HALT, O_HALT, O_HALT};
        do_reset(); opcode = 3'b111; op = 2'b00; rst = 1'b0;
        for (int c = 0; c < ev.size(); c++) begin
            tick(1'b1);
            total++;
            if (ov !== ev[c]) $display("[TB] FAIL halt cycle %0d: got %h expected %h", c + 1, ov, ev[c]);
            else passed++;
        end
        rst = 1'b1;
        tick(1'b1);
        total++;
        if (ov !== E_RST) $display("[TB] FAIL halt_clear: got %h expected %h", ov, E_RST);
        else passed++;
    endtask

    task automatic test_illegal();
        logic [23:0] ev[$];
        ev = '{E_IF1, E_UPC, E_DEC, O_HALT | O_ILL, O_HALT | O_ILL, O_HALT | O_ILL};
        do_reset(); opcode = 3'b000; op = 2'b00; rst = 1'b0;
        for (int c = 0; c < ev.size(); c++) begin
            tick(1'b1);
            total++;
            if (ov !== ev[c]) $display("[TB] FAIL illegal cycle %0d: got %h expected %h", c + 1, ov, ev[c]);
            else passed++;
        end
        rst = 1'b1;
        tick(1'b1);
        total++;
        if (ov !== E_RST) $display("[TB] FAIL illegal_clear: got %h expected %h", ov, E_RST);
        else passed++;
    endtask

    task automatic test_watchdog();
        logic [23:0] e;
        do_reset(); opcode = 3'b110; op = 2'b10; rst = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            tick(1'b0);
            e = (c <= 16) ? E_IF1W : (O_HALT | O_BERR);
            total++;
            if (ov !== e) $display("[TB] FAIL watchdog cycle %0d: got %h expected %h", c, ov, e);
            else passed++;
        end
        rst = 1'b1;
        tick(1'b1);
        total++;
        if (ov !== E_RST) $display("[TB] FAIL bus_err_clear: got %h expected %h", ov, E_RST);
        else passed++;
    endtask

    task automatic test_reset_mid_mwr();
        logic [23:0] ev[$];
        logic        rd[$];
        ev = '{E_IF1, E_UPC, E_DEC, E_GETA, E_ADDR, E_LDA, E_GETD, E_PASS, E_MWRW};
        rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset(); opcode = 3'b100; op = 2'b00; rst = 1'b0;
        for (int c = 0; c < ev.size(); c++) begin
            tick(rd[c]);
            total++;
            if (ov !== ev[c]) $display("[TB] FAIL mwr_abort cycle %0d: got %h expected %h", c + 1, ov, ev[c]);
            else passed++;
        end
        rst = 1'b1;
        tick(1'b0);
        total++;
        if (ov !== E_RST) $display("[TB] FAIL mwr_abort_rst: got %h expected %h", ov, E_RST);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [23:0] ev[$];
        ev = '{E_IF1, E_UPC, E_DEC, E_WIMM,
               E_IF1, E_UPC, E_DEC, E_GETA, E_GETB, E_EXEC, E_WBC, E_IF1};
        do_reset(); opcode = 3'b110; op = 2'b10; rst = 1'b0;
        for (int c = 0; c < ev.size(); c++) begin
            tick(1'b1);
            total++;
            if (ov !== ev[c]) $display("[TB] FAIL back_to_back cycle %0d: got %h expected %h", c + 1, ov, ev[c]);
            else passed++;
            if (c == 3) begin
                opcode = 3'b101;
                op     = 2'b10;
            end
        end
    endtask

    initial begin
        rst = 1'b1; opcode = 3'b000; op = 2'b00; mem_ready = 1'b1;
        test_reset();
        test_mov_imm();
        test_mov_shift();
        test_add();
        test_cmp();
        test_ldr_wait();
        test_str();
        test_halt();
        test_illegal();
        test_watchdog();
        test_reset_mid_mwr();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
